// File: rtl/mips_boot_pkg.sv
// Shared definitions for the MipsCPU boot path: frame magic byte, loader
// state encoding and default sizing.
package mips_boot_pkg;

    localparam logic [7:0] BOOT_MAGIC         = 8'hA5;
    localparam int         DEFAULT_ADDR_W     = 8;
    localparam int         DEFAULT_MAX_WORDS  = 256;
    localparam int         DEFAULT_RESET_HOLD = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CNT_HI  = 3'd1,
        ST_CNT_LO  = 3'd2,
        ST_DATA    = 3'd3,
        ST_CSUM    = 3'd4,
        ST_RELEASE = 3'd5,
        ST_RUN     = 3'd6,
        ST_ERROR   = 3'd7
    } state_e;

    // The loader takes host bytes only while a frame can still be received.
    function automatic logic state_accepts(input state_e s);
        return (s == ST_IDLE) || (s == ST_CNT_HI) || (s == ST_CNT_LO) ||
               (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Packs data bytes MSB-first into 32-bit words and folds every byte into a
// running XOR. word_valid_o pulses for one cycle after the fourth byte.
module boot_word_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  byte_cnt_o,
    output logic        word_valid_o,
    output logic [31:0] word_o,
    output logic [7:0]  xor_o
);

    logic [23:0] shift_q;
    logic [1:0]  cnt_q;
    logic        word_valid_q;
    logic [31:0] word_q;
    logic [7:0]  xor_q;

    // Byte shifting, word completion and checksum folding; clear wins over a byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            word_valid_q <= 1'b0;
            word_q       <= '0;
            xor_q        <= '0;
        end else begin
            word_valid_q <= 1'b0;
            if (clear_i) begin
                shift_q <= '0;
                cnt_q   <= '0;
                xor_q   <= '0;
            end else if (byte_valid_i) begin
                shift_q <= {shift_q[15:0], byte_i};
                cnt_q   <= cnt_q + 2'd1;
                xor_q   <= xor_q ^ byte_i;
                if (cnt_q == 2'd3) begin
                    word_valid_q <= 1'b1;
                    word_q       <= {shift_q, byte_i};
                end
            end
        end
    end

    assign byte_cnt_o   = cnt_q;
    assign word_valid_o = word_valid_q;
    assign word_o       = word_q;
    assign xor_o        = xor_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader for the MipsCPU: parses a framed byte stream (A5, N hi, N lo,
// 4*N data bytes, XOR checksum), writes words into instruction memory and
// keeps the CPU in reset until a clean image is in place.
//
// Handshake: a byte is transferred on a rising edge where in_valid and
// in_ready are both high; in_ready does not depend on in_valid, and a reload
// in the same cycle discards the byte.
module imem_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int MAX_WORDS  = DEFAULT_MAX_WORDS,
    parameter int RESET_HOLD = DEFAULT_RESET_HOLD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       words_loaded,
    output state_e            dbg_state_o
);

    localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);
    localparam logic [15:0] HOLD_LAST   = 16'(RESET_HOLD - 1);

    state_e              state_q, state_d;
    logic [15:0]         hold_q, hold_d;
    logic                in_ready_q;
    logic                cpu_reset_q;
    logic                load_done_q;
    logic                load_err_q;
    logic [7:0]          n_hi_q;
    logic [15:0]         n_q;
    logic [15:0]         words_loaded_q;
    logic [ADDR_W-1:0]   imem_addr_q;

    logic                accept;
    logic                data_byte;
    logic                last_byte;
    logic                last_word;
    logic                enter_cnt_hi;
    logic [15:0]         n_w;
    logic                asm_clear;
    logic [1:0]          asm_cnt;
    logic                asm_word_valid;
    logic [31:0]         asm_word;
    logic [7:0]          asm_xor;

    assign accept       = in_valid && in_ready_q && !reload;
    assign data_byte    = accept && (state_q == ST_DATA);
    assign last_byte    = data_byte && (asm_cnt == 2'd3);
    assign last_word    = last_byte && ((words_loaded_q + 16'd1) == n_q);
    assign enter_cnt_hi = accept && (state_q == ST_IDLE) && (in_data == BOOT_MAGIC);
    assign n_w          = {n_hi_q, in_data};

    boot_word_assembler u_asm (
        .clock        (clock),
        .reset        (reset),
        .clear_i      (asm_clear),
        .byte_valid_i (data_byte),
        .byte_i       (in_data),
        .byte_cnt_o   (asm_cnt),
        .word_valid_o (asm_word_valid),
        .word_o       (asm_word),
        .xor_o        (asm_xor)
    );

    // Next-state logic: reload overrides everything, else walk the frame.
    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        asm_clear = 1'b0;
        if (reload) begin
            state_d   = ST_IDLE;
            hold_d    = '0;
            asm_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enter_cnt_hi) begin
                        state_d   = ST_CNT_HI;
                        asm_clear = 1'b1;
                    end
                end
                ST_CNT_HI: begin
                    if (accept) state_d = ST_CNT_LO;
                end
                ST_CNT_LO: begin
                    if (accept) begin
                        if ((n_w == 16'd0) || ({1'b0, n_w} > MAX_WORDS_W)) begin
                            state_d = ST_ERROR;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (last_word) state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    if (accept) begin
                        if (in_data == asm_xor) begin
                            state_d = ST_RELEASE;
                            hold_d  = '0;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        hold_d = hold_q + 16'd1;
                    end
                end
                ST_RUN:   state_d = ST_RUN;
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State register plus status outputs registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            in_ready_q  <= 1'b1;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            in_ready_q  <= state_accepts(state_d);
            cpu_reset_q <= (state_d != ST_RUN);
            load_done_q <= (state_d == ST_RUN);
            load_err_q  <= (state_d == ST_ERROR);
        end
    end

    // Frame length capture, word counting and write address for each completed word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_hi_q         <= '0;
            n_q            <= '0;
            words_loaded_q <= '0;
            imem_addr_q    <= '0;
        end else begin
            if (enter_cnt_hi) begin
                words_loaded_q <= '0;
            end else if (last_byte) begin
                imem_addr_q    <= words_loaded_q[ADDR_W-1:0];
                words_loaded_q <= words_loaded_q + 16'd1;
            end
            if (accept && (state_q == ST_CNT_HI)) n_hi_q <= in_data;
            if (accept && (state_q == ST_CNT_LO)) n_q    <= n_w;
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = asm_word_valid;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = asm_word;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = load_done_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;
    assign dbg_state_o  = state_q;

endmodule
